// File: rtl/z88_rtc_irq.sv
// z88_rtc_irq: real-time clock counters and interrupt controller with a Z80 I/O register window.
// Optional alarm comparator: define Z88_RTC_ALARM_EN to add ALM0..ALM2 at D5..D7 and TSTA[3].
// All register access and prescaler stepping qualify on the bus strobe (clk_ena & bus_ph).
module z88_rtc_irq #(
   parameter int DIV_MAX       = 31250,
   parameter int TICKS_PER_SEC = 200,
   parameter int N_EXT         = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_ena,
   input  logic             bus_ph,
   input  logic             z80_io_rd,
   input  logic             z80_io_wr,
   input  logic [7:0]       z80_addr,
   input  logic [7:0]       z80_wdata,
   output logic [7:0]       z80_rdata,
   output logic             z80_int_n,
   input  logic [N_EXT-1:0] irq_in
);

   localparam int            PW       = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
   localparam logic [PW-1:0] PRE_LOAD = PW'(DIV_MAX - 1);
   localparam logic [7:0]    T0_LAST  = 8'(TICKS_PER_SEC - 1);
   localparam logic [6:0]    EXT_MASK = 7'(((1 << N_EXT) - 1) << 1);

   localparam logic [7:0] A_COM  = 8'hB0;
   localparam logic [7:0] A_INT  = 8'hB1;
   localparam logic [7:0] A_TACK = 8'hB4;
   localparam logic [7:0] A_TMSK = 8'hB5;
   localparam logic [7:0] A_ACK  = 8'hB6;
   localparam logic [7:0] A_TIM0 = 8'hD0;
   localparam logic [7:0] A_TIM1 = 8'hD1;
   localparam logic [7:0] A_TIM2 = 8'hD2;
   localparam logic [7:0] A_TIM3 = 8'hD3;
   localparam logic [7:0] A_TIM4 = 8'hD4;
   localparam logic [7:0] A_ALM0 = 8'hD5;
   localparam logic [7:0] A_ALM1 = 8'hD6;
   localparam logic [7:0] A_ALM2 = 8'hD7;

   logic             strobe;
   logic             wr_stb;
   logic             rd_stb;
   logic             wr_com;
   logic             wr_int;
   logic             wr_tack;
   logic             wr_tmsk;
   logic             wr_ack;

   logic             restim;
   logic             hold;
   logic [7:0]       int_en;
   logic [3:0]       tmsk;
   logic [3:0]       tsta;
   logic [3:0]       tsta_set;
   logic [3:0]       tsta_clr;
   logic [6:0]       sta;
   logic [6:0]       sta_set;
   logic [6:0]       sta_clr;

   logic [PW-1:0]    pre;
   logic             tick;
   logic             sec;
   logic             minute;
   logic             alarm;
   logic [7:0]       tim0;
   logic [5:0]       tim1;
   logic [7:0]       tim2;
   logic [7:0]       tim3;
   logic [4:0]       tim4;
   logic [20:0]      hms_next;

   logic [5:0]       sh1;
   logic [7:0]       sh2;
   logic [7:0]       sh3;
   logic [4:0]       sh4;

   logic [N_EXT-1:0] sync1;
   logic [N_EXT-1:0] sync2;
   logic [N_EXT-1:0] prev;
   logic [N_EXT-1:0] irq_edge;

   logic [7:0]       rd_mux;
   logic [7:0]       rdata;
   logic             int_n;

   assign strobe  = clk_ena & bus_ph;
   assign wr_stb  = strobe & z80_io_wr;
   assign rd_stb  = strobe & z80_io_rd;
   assign wr_com  = wr_stb & (z80_addr == A_COM);
   assign wr_int  = wr_stb & (z80_addr == A_INT);
   assign wr_tack = wr_stb & (z80_addr == A_TACK);
   assign wr_tmsk = wr_stb & (z80_addr == A_TMSK);
   assign wr_ack  = wr_stb & (z80_addr == A_ACK);

   // Counters are held already in the cycle that sets RESTIM, so no stale value leaks onto a following read.
   assign hold = restim | (wr_com & z80_wdata[4]);

   // Control registers: COM (only RESTIM has an effect), INT enables, TMSK.
   always_ff @(posedge clk) begin
      if (rst) begin
         restim <= 1'b0;
         int_en <= 8'h00;
         tmsk   <= 4'h0;
      end else begin
         if (wr_com)  restim <= z80_wdata[4];
         if (wr_int)  int_en <= z80_wdata;
         if (wr_tmsk) tmsk   <= z80_wdata[3:0];
      end
   end

   // pre counts strobes remaining before the next 5 ms tick; reloading it means "no strobes elapsed".
   assign tick     = strobe & ~hold & (pre == '0);
   assign sec      = tick & (tim0 == T0_LAST);
   assign minute   = sec & (tim1 == 6'd59);
   assign hms_next = {tim4, tim3, tim2} + 21'd1;

   // Prescaler down-counter with terminal-count reload.
   always_ff @(posedge clk) begin
      if (rst || hold) begin
         pre <= PRE_LOAD;
      end else if (strobe) begin
         pre <= (pre == '0) ? PRE_LOAD : pre - 1'b1;
      end
   end

   // Time-of-day chain: ticks -> seconds -> minutes -> 21-bit minute count across TIM2..TIM4.
   always_ff @(posedge clk) begin
      if (rst || hold) begin
         tim0 <= 8'h00;
         tim1 <= 6'd0;
         tim2 <= 8'h00;
         tim3 <= 8'h00;
         tim4 <= 5'd0;
      end else begin
         if (tick)   tim0 <= sec ? 8'h00 : tim0 + 8'd1;
         if (sec)    tim1 <= minute ? 6'd0 : tim1 + 6'd1;
         if (minute) {tim4, tim3, tim2} <= hms_next;
      end
   end

`ifdef Z88_RTC_ALARM_EN
   logic [7:0] alm0;
   logic [7:0] alm1;
   logic [4:0] alm2;

   // Alarm compare registers, writable in all RESTIM states.
   always_ff @(posedge clk) begin
      if (rst) begin
         alm0 <= 8'h00;
         alm1 <= 8'h00;
         alm2 <= 5'd0;
      end else begin
         if (wr_stb && z80_addr == A_ALM0) alm0 <= z80_wdata;
         if (wr_stb && z80_addr == A_ALM1) alm1 <= z80_wdata;
         if (wr_stb && z80_addr == A_ALM2) alm2 <= z80_wdata[4:0];
      end
   end

   assign alarm = minute & (hms_next == {alm2, alm1, alm0});
`else
   assign alarm = 1'b0;
`endif

   assign tsta_set = {alarm & tmsk[3], minute & tmsk[2], sec & tmsk[1], tick & tmsk[0]};
   assign tsta_clr = wr_tack ? z80_wdata[3:0] : 4'h0;

   // Timer status: sticky until acknowledged; a set in the same cycle as its clear wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         tsta <= 4'h0;
      end else begin
         tsta <= (tsta & ~tsta_clr) | tsta_set;
      end
   end

   // Two-flop synchroniser plus previous-value register for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= irq_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign irq_edge = sync2 & ~prev;
   assign sta_set  = 7'({irq_edge, 1'b0}) & int_en[6:0];
   assign sta_clr  = wr_ack ? z80_wdata[6:0] : 7'h00;

   // Interrupt status: bit 0 mirrors enabled timer status, bits 1..N_EXT latch enabled external edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         sta <= 7'h00;
      end else begin
         sta <= (((sta & ~sta_clr) | sta_set) & EXT_MASK) | {6'b0, (|tsta) & int_en[0]};
      end
   end

   // Interrupt output, one clock behind STA.
   always_ff @(posedge clk) begin
      if (rst) begin
         int_n <= 1'b1;
      end else begin
         int_n <= ~(int_en[7] & (|sta));
      end
   end

   // Reading TIM0 freezes TIM1..TIM4 so a multi-byte time read is coherent.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh1 <= 6'd0;
         sh2 <= 8'h00;
         sh3 <= 8'h00;
         sh4 <= 5'd0;
      end else if (rd_stb && z80_addr == A_TIM0) begin
         sh1 <= tim1;
         sh2 <= tim2;
         sh3 <= tim3;
         sh4 <= tim4;
      end
   end

   // Read-port decode; anything not listed reads 00.
   always_comb begin
      rd_mux = 8'h00;
      case (z80_addr)
         A_INT:  rd_mux = {1'b0, sta};
         A_TMSK: rd_mux = {4'h0, tsta};
         A_TIM0: rd_mux = tim0;
         A_TIM1: rd_mux = {2'b00, sh1};
         A_TIM2: rd_mux = sh2;
         A_TIM3: rd_mux = sh3;
         A_TIM4: rd_mux = {3'b000, sh4};
`ifdef Z88_RTC_ALARM_EN
         A_ALM0: rd_mux = alm0;
         A_ALM1: rd_mux = alm1;
         A_ALM2: rd_mux = {3'b000, alm2};
`endif
         default: rd_mux = 8'h00;
      endcase
   end

   // Read data register: captured on a read strobe, returned to 00 on any other strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= 8'h00;
      end else if (strobe) begin
         rdata <= z80_io_rd ? rd_mux : 8'h00;
      end
   end

   assign z80_rdata = rdata;
   assign z80_int_n = int_n;

endmodule

// File: tb/tb_z88_rtc_irq.sv
// Directed bench for z88_rtc_irq with DIV_MAX=4, TICKS_PER_SEC=4, N_EXT=2.
// Every bus access is one strobe cycle; idle cycles carry no strobe, so strobe counts are exact.
module tb_z88_rtc_irq;

   logic       clk = 1'b0;
   logic       rst;
   logic       clk_ena;
   logic       bus_ph;
   logic       z80_io_rd;
   logic       z80_io_wr;
   logic [7:0] z80_addr;
   logic [7:0] z80_wdata;
   logic [7:0] z80_rdata;
   logic       z80_int_n;
   logic [1:0] irq_in;

   int checks   = 0;
   int failures = 0;

   z88_rtc_irq #(.DIV_MAX(4), .TICKS_PER_SEC(4), .N_EXT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .clk_ena   (clk_ena),
      .bus_ph    (bus_ph),
      .z80_io_rd (z80_io_rd),
      .z80_io_wr (z80_io_wr),
      .z80_addr  (z80_addr),
      .z80_wdata (z80_wdata),
      .z80_rdata (z80_rdata),
      .z80_int_n (z80_int_n),
      .irq_in    (irq_in)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One strobe cycle; called and returns at a falling edge.
   task automatic bus_op(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wd);
      clk_ena   = 1'b1;
      bus_ph    = 1'b1;
      z80_io_rd = rd;
      z80_io_wr = wr;
      z80_addr  = addr;
      z80_wdata = wd;
      @(negedge clk);
      clk_ena   = 1'b0;
      bus_ph    = 1'b0;
      z80_io_rd = 1'b0;
      z80_io_wr = 1'b0;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] wd);
      bus_op(1'b0, 1'b1, addr, wd);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      bus_op(1'b1, 1'b0, addr, 8'h00);
      check(tag, z80_rdata, exp);
   endtask

   task automatic nop_strobe(input int n);
      for (int i = 0; i < n; i++) bus_op(1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; clk_ena = 1'b0; bus_ph = 1'b0; z80_io_rd = 1'b0; z80_io_wr = 1'b0;
      z80_addr = 8'h00; z80_wdata = 8'h00; irq_in = 2'b00;
      idle(2);
      check("rst_int_n", {7'b0, z80_int_n}, 8'h01);
      check("rst_rdata", z80_rdata, 8'h00);
      rst = 1'b0;

      // Hold counters, confirm cleared state
      wr(8'hB0, 8'h10);
      rd_chk("rst_tim0", 8'hD0, 8'h00);
      rd_chk("rst_sta", 8'hB1, 8'h00);
      rd_chk("rst_tsta", 8'hB5, 8'h00);
      rd_chk("unmapped_b2", 8'hB2, 8'h00);

      // Tick every 4th strobe, STA[0] and z80_int_n chain
      wr(8'hB5, 8'h01);
      wr(8'hB1, 8'h81);
      wr(8'hB0, 8'h00);
      nop_strobe(4);
      rd_chk("tick1_tsta", 8'hB5, 8'h01);
      check("tick1_int_n_hi", {7'b0, z80_int_n}, 8'h01);
      nop_strobe(1);
      check("rdata_clear", z80_rdata, 8'h00);
      check("tick1_int_n_lo", {7'b0, z80_int_n}, 8'h00);
      rd_chk("tick1_sta", 8'hB1, 8'h01);
      wr(8'hB4, 8'h01);
      rd_chk("tack_set_wins", 8'hB5, 8'h01);
      wr(8'hB4, 8'h01);
      rd_chk("tack_cleared", 8'hB5, 8'h00);
      nop_strobe(1);
      rd_chk("tick3_tsta", 8'hB5, 8'h01);

      // Minute rollover: 239 ticks then one more
      wr(8'hB0, 8'h10);
      wr(8'hB4, 8'h0F);
      wr(8'hB5, 8'h04);
      wr(8'hB0, 8'h00);
      nop_strobe(956);
      rd_chk("pre_min_tim0", 8'hD0, 8'h03);
      rd_chk("pre_min_tim1", 8'hD1, 8'h3B);
      rd_chk("pre_min_tsta", 8'hB5, 8'h00);
      nop_strobe(1);
      rd_chk("min_tim0", 8'hD0, 8'h00);
      rd_chk("min_tim1", 8'hD1, 8'h00);
      rd_chk("min_tim2", 8'hD2, 8'h01);
      rd_chk("min_tsta", 8'hB5, 8'h04);

      // Shadow coherence: TIM1 changes between TIM0 and D1 reads
      rd_chk("shadow_tim0", 8'hD0, 8'h01);
      nop_strobe(11);
      rd_chk("shadow_old_tim1", 8'hD1, 8'h00);
      rd_chk("shadow_tim0b", 8'hD0, 8'h00);
      rd_chk("shadow_new_tim1", 8'hD1, 8'h01);

      // RESTIM mid-count
      wr(8'hB4, 8'h0F);
      wr(8'hB5, 8'h07);
      rd_chk("mid_tim0", 8'hD0, 8'h01);
      wr(8'hB0, 8'h10);
      nop_strobe(8);
      rd_chk("restim_tim0", 8'hD0, 8'h00);
      rd_chk("restim_tim1", 8'hD1, 8'h00);
      rd_chk("restim_tim2", 8'hD2, 8'h00);
      rd_chk("restim_tim3", 8'hD3, 8'h00);
      rd_chk("restim_tim4", 8'hD4, 8'h00);
      rd_chk("restim_tsta", 8'hB5, 8'h00);
      wr(8'hB0, 8'h00);
      nop_strobe(3);
      rd_chk("resume_tim0_0", 8'hD0, 8'h00);
      rd_chk("resume_tim0_1", 8'hD0, 8'h01);
      rd_chk("resume_tsta", 8'hB5, 8'h01);

`ifdef Z88_RTC_ALARM_EN
      // Alarm at minute count 2
      wr(8'hB0, 8'h10);
      wr(8'hB4, 8'h0F);
      wr(8'hB5, 8'h08);
      wr(8'hD5, 8'h02);
      wr(8'hD6, 8'h00);
      wr(8'hD7, 8'h00);
      wr(8'hB0, 8'h00);
      nop_strobe(1919);
      rd_chk("alarm_before", 8'hB5, 8'h00);
      rd_chk("alarm_hit", 8'hB5, 8'h08);
      rd_chk("alarm_alm0", 8'hD5, 8'h02);
`else
      wr(8'hD5, 8'h55);
      rd_chk("no_alarm_d5", 8'hD5, 8'h00);
      rd_chk("no_alarm_d7", 8'hD7, 8'h00);
`endif

      // External interrupt edge and ACK collision
      wr(8'hB0, 8'h10);
      wr(8'hB4, 8'h0F);
      wr(8'hB1, 8'h84);
      irq_in = 2'b10;
      idle(3);
      rd_chk("ext_sta", 8'hB1, 8'h04);
      check("ext_int_n_lo", {7'b0, z80_int_n}, 8'h00);
      irq_in = 2'b00;
      idle(3);
      irq_in = 2'b10;
      idle(2);
      wr(8'hB6, 8'h04);
      rd_chk("ack_set_wins", 8'hB1, 8'h04);
      wr(8'hB6, 8'h04);
      rd_chk("ack_cleared", 8'hB1, 8'h00);
      check("ack_int_n_hi", {7'b0, z80_int_n}, 8'h01);

      // Reset beats a simultaneous write
      irq_in = 2'b00;
      idle(3);
      irq_in = 2'b10;
      idle(4);
      check("pre_rst_int_n", {7'b0, z80_int_n}, 8'h00);
      rst = 1'b1;
      wr(8'hB1, 8'h84);
      rst = 1'b0;
      check("rst2_int_n", {7'b0, z80_int_n}, 8'h01);
      check("rst2_rdata", z80_rdata, 8'h00);
      irq_in = 2'b00;
      idle(3);
      irq_in = 2'b10;
      idle(4);
      rd_chk("rst2_sta", 8'hB1, 8'h00);
      check("rst2_int_n_after", {7'b0, z80_int_n}, 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/z88_rtc_irq.md
Z88_RTC_IRQ -- requirements
Module: z88_rtc_irq

Interface
REQ-001 SHALL provide parameter DIV_MAX, default 31250: prescaler terminal count, in enabled cycles per 5 ms tick.
REQ-002 SHALL provide parameter TICKS_PER_SEC, default 200: TIM0 modulus, legal range 2..256.
REQ-003 SHALL provide parameter N_EXT, default 2: number of external interrupt sources, legal range 1..6.
REQ-004 SHALL provide ports, one per line:
 clk  in  1  master clock; single clock domain.
 rst  in  1  reset, synchronous, active-high.
 clk_ena  in  1  bus clock enable.
 bus_ph  in  1  bus phase; 1 = Z80 phase.
 z80_io_rd  in  1  I/O read strobe.
 z80_io_wr  in  1  I/O write strobe.
 z80_addr  in  8  I/O port address.
 z80_wdata  in  8  write data.
 z80_rdata  out  8  registered read data.
 z80_int_n  out  1  maskable interrupt, active-low.
 irq_in  in  N_EXT  asynchronous external interrupt lines.

Function
REQ-005 SHALL define "bus strobe" as clk_ena & bus_ph; every register access and every prescaler step SHALL qualify on it.
REQ-006 SHALL decode these ports: B0 COM (write), B1 INT (write) / STA (read), B4 TACK (write, 4 bits), B5 TMSK (write, 4 bits) / TSTA (read), B6 ACK (write), D0..D4 TIM0..TIM4 (read).
REQ-007 SHALL hold the prescaler and TIM0..TIM4 at 0 and suppress all timer events while COM[4] (RESTIM) = 1.
REQ-008 SHALL step the prescaler from 0 to DIV_MAX-1 on each bus strobe; the strobe that finds DIV_MAX-1 wraps it to 0 and produces a tick.
REQ-009 SHALL advance the counters as follows: on a tick, TIM0 increments and wraps at TICKS_PER_SEC-1, producing a second; on a second, TIM1 wraps 59 to 0, producing a minute; on a minute, TIM2 (8 bits) increments, carrying into TIM3 (8 bits) and then TIM4 (5 bits); TIM4 wraps 31 to 0 silently.
REQ-010 SHALL set TSTA[0], TSTA[1] and TSTA[2] on the clock edge after a tick, second or minute event respectively, only if the matching TMSK bit is 1.
REQ-011 SHALL clear each TSTA bit whose TACK bit is written as 1; TACK and ACK are write pulses, not stored; a set arriving in the same cycle as its clear SHALL win.
REQ-012 SHALL pass each irq_in bit through a 2-flop synchroniser and detect rising edges; an edge on source k sets STA[k+1] if INT[k+1] = 1; an ACK write with bit k+1 = 1 clears it, and set wins over clear.
REQ-013 SHALL drive STA[0] = |TSTA & INT[0], registered; STA bits above N_EXT SHALL read 0.
REQ-014 SHALL drive z80_int_n = ~(INT[7] & |STA[6:0]), registered, so z80_int_n follows STA by one clock.
REQ-015 SHALL capture z80_rdata on a bus strobe with z80_io_rd = 1 and set it to 00 on a bus strobe with z80_io_rd = 0; unmapped ports SHALL read 00; unused high bits SHALL read 0.
REQ-016 SHALL copy TIM1..TIM4 into shadow registers on every read of TIM0; reads of D1..D4 SHALL return the shadow, giving a coherent multi-byte time read.
REQ-017 SHALL NOT clear any status bit on a read; only ACK and TACK writes clear status.

Reset
REQ-018 SHALL, with rst = 1 at a clk edge, clear COM, INT, TMSK, TSTA, STA, the prescaler, TIM0..TIM4, the shadows, the synchronisers, the edge detectors and z80_rdata, and set z80_int_n = 1.
REQ-019 SHALL give rst priority over any simultaneous bus write or event; an event in the reset cycle SHALL be discarded.

Configuration
REQ-020 SHALL, with macro Z88_RTC_ALARM_EN defined, add ALM0 (D5), ALM1 (D6) and ALM2[4:0] (D7), all read/write, reset 0; when a minute event makes the new {TIM4,TIM3,TIM2} equal {ALM2,ALM1,ALM0}, TSTA[3] SHALL set with TMSK[3], using the same timing as TSTA[2].
REQ-021 SHALL, without Z88_RTC_ALARM_EN, ignore writes to D5..D7, read them as 00, and tie TSTA[3] to 0.

Verification
REQ-022 SHALL cover: DIV_MAX=4, TICKS_PER_SEC=4, continuous bus strobes, TMSK=1, INT=81 -> TSTA[0]=1 one clock after every 4th strobe, z80_int_n low one clock after STA[0].
REQ-023 SHALL cover: run the counters to TIM1=59, TIM0=3, then one tick -> TIM1=0, TIM2=1, TSTA[2] set when TMSK[2]=1.
REQ-024 SHALL cover: irq_in[1] rising while INT=84 -> STA[2]=1 within 3 clocks; write ACK=04 in the same cycle as a new edge -> STA[2] stays 1.
REQ-025 SHALL cover: read TIM0, then force TIM1 to change, then read D1 -> the pre-change value is returned.
REQ-026 SHALL cover: write COM=10 mid-count -> all TIM read 00 and no TSTA set; write COM=00 -> counting resumes from 0.
REQ-027 SHALL cover, with the alarm compiled in: ALM = 00/00/02, TMSK=8 -> TSTA[3] sets exactly at the second minute; without the macro, a read of D5 returns 00.
